// File: rtl/frame_max_backlight_ctrl.sv
// Converts per-frame maximum gray into a smoothed, slew-limited backlight PWM duty,
// applied on PWM period boundaries. Optional no-signal timeout under `BL_TIMEOUT_EN.
module frame_max_backlight_ctrl #(
  parameter int unsigned PWM_W        = 10,
  parameter int unsigned FILTER_SHIFT = 2,
  parameter int unsigned MAX_STEP     = 16,
  parameter int unsigned MIN_PWM      = 32
`ifdef BL_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       frame_max,
  input  logic             frame_max_valid,
  input  logic             sync_signal,
  output logic [PWM_W-1:0] pwm_value,
  output logic             pwm_update,
  output logic             busy,
  output logic             overrun,
  output logic             timeout
);

  localparam int unsigned ACC_W = PWM_W + FILTER_SHIFT;
  localparam int unsigned DW    = PWM_W + 1;
  localparam logic [PWM_W-1:0]        PWM_MAX  = {PWM_W{1'b1}};
  localparam logic [ACC_W-1:0]        ACC_INIT = ACC_W'(PWM_MAX) << FILTER_SHIFT;
  localparam logic signed [PWM_W:0]   STEP_POS = DW'(MAX_STEP);
  localparam logic signed [PWM_W:0]   STEP_NEG = -STEP_POS;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_FILTER, S_LIMIT} state_t;

  state_t              state, state_n;
  logic [7:0]          fm_q;
  logic [PWM_W-1:0]    target, filt, pending;
  logic [ACC_W-1:0]    acc;
  logic                sync_prev;

  logic                sync_rise_c;
  logic [PWM_W-1:0]    rep_c, target_c, filt_c, limit_c;
  logic [ACC_W-1:0]    acc_new_c;
  logic signed [PWM_W:0] diff_c;
  logic                timeout_hit_c;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state: one pass of LATCH/FILTER/LIMIT per accepted strobe
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (frame_max_valid) state_n = S_LATCH;
      S_LATCH:  state_n = S_FILTER;
      S_FILTER: state_n = S_LIMIT;
      S_LIMIT:  state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Datapath arithmetic
  always_comb begin
    sync_rise_c = sync_signal && !sync_prev;
    rep_c       = {fm_q, fm_q[7:6]};
    target_c    = (rep_c < PWM_W'(MIN_PWM)) ? PWM_W'(MIN_PWM) : rep_c;
    acc_new_c   = acc - (acc >> FILTER_SHIFT) + ACC_W'(target);
    filt_c      = PWM_W'(acc_new_c >> FILTER_SHIFT);
    diff_c      = $signed({1'b0, filt}) - $signed({1'b0, pending});
    if (diff_c > STEP_POS)      limit_c = pending + PWM_W'(MAX_STEP);
    else if (diff_c < STEP_NEG) limit_c = pending - PWM_W'(MAX_STEP);
    else                        limit_c = filt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fm_q       <= '0;
      target     <= '0;
      filt       <= '0;
      acc        <= ACC_INIT;
      pending    <= PWM_MAX;
      pwm_value  <= PWM_MAX;
      pwm_update <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      sync_prev  <= 1'b0;
    end else begin
      sync_prev  <= sync_signal;
      pwm_update <= sync_rise_c;
      if (sync_rise_c) pwm_value <= pending;
      busy    <= (state_n != S_IDLE);
      overrun <= frame_max_valid && (state != S_IDLE);
      if (state == S_IDLE && frame_max_valid) fm_q <= frame_max;
      case (state)
        S_LATCH:  target <= target_c;
        S_FILTER: begin
          acc  <= acc_new_c;
          filt <= filt_c;
        end
        S_LIMIT:  pending <= limit_c;
        default:  ;
      endcase
      // Lost signal: fall back to full backlight
      if (timeout_hit_c) begin
        pending <= PWM_MAX;
        acc     <= ACC_INIT;
      end
    end
  end

`ifdef BL_TIMEOUT_EN
  logic [23:0] idle_cnt;

  assign timeout_hit_c = !frame_max_valid && (idle_cnt != TIMEOUT_CYCLES) &&
                         (idle_cnt + 24'd1 == TIMEOUT_CYCLES);

  // Cycles since last strobe, saturating at the timeout threshold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (frame_max_valid) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (idle_cnt != TIMEOUT_CYCLES) idle_cnt <= idle_cnt + 24'd1;
      if (timeout_hit_c) timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit_c = 1'b0;

  always_ff @(posedge clk) begin
    timeout <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_frame_max_backlight_ctrl.sv
// Directed, table-driven bench for frame_max_backlight_ctrl; build with +define+BL_TIMEOUT_EN
// to also exercise the timeout path (threshold reduced to 1000 cycles).
module tb_frame_max_backlight_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] frame_max = '0;
  logic       frame_max_valid = 1'b0;
  logic       sync_signal = 1'b0;
  logic [9:0] pwm_value;
  logic       pwm_update, busy, overrun, timeout;

  int checks = 0;
  int errors = 0;

  frame_max_backlight_ctrl #(
`ifdef BL_TIMEOUT_EN
    .TIMEOUT_CYCLES(24'd1000)
`endif
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_max       (frame_max),
    .frame_max_valid (frame_max_valid),
    .sync_signal     (sync_signal),
    .pwm_value       (pwm_value),
    .pwm_update      (pwm_update),
    .busy            (busy),
    .overrun         (overrun),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] fm;
    int         exp_pwm;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    frame_max_valid = 1'b0;
    sync_signal = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] fm);
    frame_max = fm;
    frame_max_valid = 1'b1;
    step();
    frame_max_valid = 1'b0;
    check("busy_latch", busy, 1);
    step();
    step();
    step();
    check("busy_done", busy, 0);
  endtask

  task automatic sync_apply(input int exp);
    sync_signal = 1'b1;
    step();
    check("pwm_value", pwm_value, exp);
    check("pwm_update_pulse", pwm_update, 1);
    step();
    check("pwm_update_held", pwm_update, 0);
    sync_signal = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'd255, 1023};
    vecs[1]  = '{8'd255, 1023};
    vecs[2]  = '{8'd128, 1007};
    vecs[3]  = '{8'd128, 991};
    vecs[4]  = '{8'd128, 975};
    vecs[5]  = '{8'd128, 959};
    vecs[6]  = '{8'd0,   943};
    vecs[7]  = '{8'd10,  927};
    vecs[8]  = '{8'd7,   911};
    vecs[9]  = '{8'd255, 895};
    vecs[10] = '{8'd255, 879};
    vecs[11] = '{8'd255, 863};
    vecs[12] = '{8'd255, 847};
    vecs[13] = '{8'd255, 852};
    vecs[14] = '{8'd255, 868};

    // Reset state and first apply
    do_reset();
    check("rst_pwm_value", pwm_value, 1023);
    check("rst_pwm_update", pwm_update, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    sync_apply(1023);
    check("idle_busy", busy, 0);

    // First frame from reset is slew limited
    run_frame(8'd0);
    check("no_sync_no_update", pwm_update, 0);
    check("pwm_before_sync", pwm_value, 1023);
    sync_apply(1007);

    // Table: filter and slew across many frames
    do_reset();
    foreach (vecs[i]) begin
      run_frame(vecs[i].fm);
      sync_apply(vecs[i].exp_pwm);
    end

    // Small change passes straight through
    do_reset();
    run_frame(8'd252);
    sync_apply(1020);

    // Overrun: second strobe two cycles after the first is dropped
    do_reset();
    frame_max = 8'd0;
    frame_max_valid = 1'b1;
    step();
    frame_max_valid = 1'b0;
    step();
    frame_max = 8'd255;
    frame_max_valid = 1'b1;
    step();
    frame_max_valid = 1'b0;
    check("overrun_pulse", overrun, 1);
    step();
    check("overrun_clear", overrun, 0);
    check("overrun_busy", busy, 0);
    step();
    check("overrun_still_idle", busy, 0);
    sync_apply(1007);

    // LIMIT cycle coincides with sync rising edge
    do_reset();
    frame_max = 8'd0;
    frame_max_valid = 1'b1;
    step();
    frame_max_valid = 1'b0;
    step();
    step();
    sync_signal = 1'b1;
    step();
    check("collide_pwm_old", pwm_value, 1023);
    check("collide_update", pwm_update, 1);
    sync_signal = 1'b0;
    step();
    sync_apply(1007);

    // Reset during FILTER discards the frame
    frame_max = 8'd0;
    frame_max_valid = 1'b1;
    step();
    frame_max_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    check("midrst_pwm_value", pwm_value, 1023);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_update", pwm_update, 0);
    reset_n = 1'b1;
    step();
    check("midrst_stays_idle", busy, 0);
    sync_apply(1023);
    run_frame(8'd0);
    sync_apply(1007);

`ifdef BL_TIMEOUT_EN
    // No-signal timeout forces full backlight; next strobe clears it
    do_reset();
    run_frame(8'd0);
    sync_apply(1007);
    for (int i = 0; i < 1100 && !timeout; i++) step();
    check("timeout_set", timeout, 1);
    sync_apply(1023);
    frame_max = 8'd0;
    frame_max_valid = 1'b1;
    step();
    frame_max_valid = 1'b0;
    check("timeout_cleared", timeout, 0);
    step();
    step();
    step();
    sync_apply(1007);
`else
    check("timeout_tied_low", timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
